axil_read_sub: RTL and testbench

AXIL_READ_SUB -- requirements
Module: axil_read_sub

---
 rtl/axil_read_sub_if.sv | 15 +
 rtl/axil_read_sub.sv | 68 ++++++
 tb/tb_axil_read_sub.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axil_read_sub_if.sv
// axil_read_sub_if: AXI-Lite read channel (AR + R) bundle
interface axil_read_sub_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    modport master (output ARADDR, ARVALID, RREADY, input ARREADY, RDATA, RRESP, RVALID);
    modport slave  (input ARADDR, ARVALID, RREADY, output ARREADY, RDATA, RRESP, RVALID);
endinterface

// File: rtl/axil_read_sub.sv
// axil_read_sub: AXI-Lite read-only register subordinate with a local write port
module axil_read_sub #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    axil_read_sub_if.slave              s_axil,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
    input  logic [DATA_W-1:0]           wr_data,
    output logic [15:0]                 rd_count
);
    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int IDX_W = $clog2(NUM_REGS);
    typedef enum logic {IDLE, RESP} state_t;
    state_t            r_state, w_next;
    logic              r_arready, r_rvalid;
    logic              w_ar_hs, w_r_hs, w_slverr, w_decerr;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [1:0]        r_rresp;
    logic [15:0]       r_count;
    logic [IDX_W-1:0]  w_idx;
    assign w_ar_hs  = r_arready && s_axil.ARVALID;
    assign w_r_hs   = r_rvalid && s_axil.RREADY;
    assign w_slverr = |s_axil.ARADDR[OFF_W-1:0];
    assign w_decerr = |(s_axil.ARADDR >> (OFF_W + IDX_W));
    assign w_idx    = s_axil.ARADDR[OFF_W +: IDX_W];
    always_comb begin
        w_next = (r_state == IDLE) ? (w_ar_hs ? RESP : IDLE) : (w_r_hs ? IDLE : RESP);
    end
    // Handshake flags come from the next state so ARREADY/RVALID stay registered
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_count   <= '0;
        end else begin
            r_state   <= w_next;
            r_arready <= (w_next == IDLE);
            r_rvalid  <= (w_next == RESP);
            if (w_ar_hs) begin
                r_rdata <= (w_slverr || w_decerr) ? '0 : r_regs[w_idx];
                r_rresp <= w_slverr ? 2'b10 : w_decerr ? 2'b11 : 2'b00;
            end
            if (w_r_hs)
                r_count <= r_count + 16'd1;
        end
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (wr_en) begin
            r_regs[wr_idx] <= wr_data;
        end
    end
    assign s_axil.ARREADY = r_arready;
    assign s_axil.RVALID  = r_rvalid;
    assign s_axil.RDATA   = r_rdata;
    assign s_axil.RRESP   = r_rresp;
    assign rd_count       = r_count;
endmodule

// File: tb/tb_axil_read_sub.sv
// tb_axil_read_sub: directed stimulus checked against a behavioural register-file model
module tb_axil_read_sub;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [63:0] wr_data;
    logic [15:0] rd_count;
    int          total = 0;
    int          bad = 0;
    logic        m_started = 1'b0, m_busy = 1'b0;
    logic [63:0] m_data = '0;
    logic [1:0]  m_resp = '0;
    logic [15:0] m_cnt = '0;
    logic [63:0] m_regs [16];
    logic        pre_en = 1'b0;
    logic [15:0] pre_val = '0;
    logic [63:0] d;
    logic [1:0]  r;

    axil_read_sub_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axil_read_sub #(.ADDR_W(32), .DATA_W(64), .NUM_REGS(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axil(bus),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rd_count(rd_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: one outstanding read, response computed from address arithmetic
    always @(posedge ACLK or posedge ARESET) begin
        logic [31:0] a;
        if (ARESET) begin
            m_started = 0; m_busy = 0; m_data = 0; m_resp = 0; m_cnt = 0;
            for (int i = 0; i < 16; i++) m_regs[i] = 0;
        end else begin
            if (m_started && !m_busy && bus.ARVALID) begin
                a = bus.ARADDR;
                if (a % 8 != 0) begin m_resp = 2'b10; m_data = 0; end
                else if (a / 128 != 0) begin m_resp = 2'b11; m_data = 0; end
                else begin m_resp = 2'b00; m_data = m_regs[(a / 8) % 16]; end
                m_busy = 1;
            end else if (m_busy && bus.RREADY) begin
                m_busy = 0;
                m_cnt = m_cnt + 16'd1;
            end
            if (wr_en) m_regs[wr_idx] = wr_data;
            if (pre_en) m_cnt = pre_val;
            m_started = 1;
        end
    end

    always @(negedge ACLK) begin
        chk("ARREADY", {63'd0, bus.ARREADY}, {63'd0, m_started && !m_busy});
        chk("RVALID", {63'd0, bus.RVALID}, {63'd0, m_busy});
        chk("RDATA", bus.RDATA, m_data);
        chk("RRESP", {62'd0, bus.RRESP}, {62'd0, m_resp});
        chk("rd_count", {48'd0, rd_count}, {48'd0, m_cnt});
    end

    task automatic wr(input logic [3:0] i, input logic [63:0] v);
        wr_en = 1; wr_idx = i; wr_data = v;
        @(posedge ACLK); #1 wr_en = 0;
    endtask

    task automatic ar(input logic [31:0] a);
        int n = 0;
        bus.ARADDR = a; bus.ARVALID = 1;
        @(negedge ACLK);
        while (!bus.ARREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL ar_wait actual=timeout required=ARREADY"); end
        @(posedge ACLK); #1 bus.ARVALID = 0;
    endtask

    task automatic rcv(output logic [63:0] od, output logic [1:0] orr);
        int n = 0;
        @(negedge ACLK);
        while (!bus.RVALID && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL r_wait actual=timeout required=RVALID"); end
        od = bus.RDATA; orr = bus.RRESP;
        bus.RREADY = 1;
        @(posedge ACLK); #1 bus.RREADY = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        ARESET = 1; bus.ARVALID = 0; bus.ARADDR = 0; bus.RREADY = 0;
        wr_en = 0; wr_idx = 0; wr_data = 0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_arready", {63'd0, bus.ARREADY}, 64'd0);
        chk("rst_rvalid", {63'd0, bus.RVALID}, 64'd0);
        chk("rst_count", {48'd0, rd_count}, 64'd0);
        ARESET = 0;
        @(posedge ACLK); #1;
        chk("rel_arready", {63'd0, bus.ARREADY}, 64'd1);
        // Basic read with RREADY already high
        wr(3, 64'hDEAD_BEEF_0123_4567);
        bus.RREADY = 1;
        ar(32'h18);
        chk("s35_rvalid", {63'd0, bus.RVALID}, 64'd1);
        chk("s35_rdata", bus.RDATA, 64'hDEAD_BEEF_0123_4567);
        chk("s35_rresp", {62'd0, bus.RRESP}, 64'd0);
        chk("s35_model", m_data, 64'hDEAD_BEEF_0123_4567);
        @(posedge ACLK); #1;
        chk("s35_rvalid_done", {63'd0, bus.RVALID}, 64'd0);
        chk("s35_arready_back", {63'd0, bus.ARREADY}, 64'd1);
        chk("s35_count", {48'd0, rd_count}, 64'd1);
        bus.RREADY = 0;
        // Error responses
        ar(32'h1C); rcv(d, r);
        chk("s36_slv_data", d, 64'd0); chk("s36_slv_resp", {62'd0, r}, 64'd2);
        ar(32'h80); rcv(d, r);
        chk("s36_dec_data", d, 64'd0); chk("s36_dec_resp", {62'd0, r}, 64'd3);
        ar(32'h81); rcv(d, r);
        chk("slv_prio_resp", {62'd0, r}, 64'd2);
        ar(32'h1000_0018); rcv(d, r);
        chk("dec_high_resp", {62'd0, r}, 64'd3);
        chk("err_count", {48'd0, rd_count}, 64'd5);
        wr(15, 64'h0123_4567_89AB_CDEF);
        ar(32'h78); rcv(d, r);
        chk("reg15_data", d, 64'h0123_4567_89AB_CDEF);
        ar(32'h08); rcv(d, r);
        chk("reg1_zero", d, 64'd0); chk("reg1_resp", {62'd0, r}, 64'd0);
        // Stall with local overwrite during RESP
        ar(32'h18);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("s37_rdata", bus.RDATA, 64'hDEAD_BEEF_0123_4567);
            chk("s37_rresp", {62'd0, bus.RRESP}, 64'd0);
            chk("s37_arready", {63'd0, bus.ARREADY}, 64'd0);
            chk("s37_rvalid", {63'd0, bus.RVALID}, 64'd1);
            if (i == 1) begin wr_en = 1; wr_idx = 3; wr_data = 0; end
            if (i == 2) wr_en = 0;
        end
        bus.RREADY = 1;
        @(posedge ACLK); #1 bus.RREADY = 0;
        chk("s37_arready_after", {63'd0, bus.ARREADY}, 64'd1);
        ar(32'h18); rcv(d, r);
        chk("s37_new_val", d, 64'd0);
        // AR ignored while a response is pending
        wr(3, 64'd5);
        ar(32'h18);
        bus.ARADDR = 32'h1C; bus.ARVALID = 1;
        repeat (2) @(negedge ACLK);
        bus.ARVALID = 0;
        rcv(d, r);
        chk("s29_data", d, 64'd5); chk("s29_resp", {62'd0, r}, 64'd0);
        // Same-edge write does not leak into the captured data
        wr(2, 64'd7);
        wr_en = 1; wr_idx = 2; wr_data = 64'd1;
        ar(32'h10);
        wr_en = 0;
        rcv(d, r);
        chk("s38_old", d, 64'd7);
        ar(32'h10); rcv(d, r);
        chk("s38_new", d, 64'd1);
        // Counter wrap
        pre_en = 1; pre_val = 16'hFFFE;
        @(posedge ACLK); #1;
        force dut.r_count = 16'hFFFE;
        pre_en = 0;
        @(posedge ACLK); #1;
        release dut.r_count;
        ar(32'h08); rcv(d, r);
        chk("s39_ffff", {48'd0, rd_count}, 64'hFFFF);
        ar(32'h08); rcv(d, r);
        chk("s39_wrap", {48'd0, rd_count}, 64'd0);
        // Reset in the middle of a response
        wr(4, 64'h55);
        ar(32'h20);
        #2 ARESET = 1;
        #1;
        chk("s40_rvalid", {63'd0, bus.RVALID}, 64'd0);
        chk("s40_arready", {63'd0, bus.ARREADY}, 64'd0);
        chk("s40_rdata", bus.RDATA, 64'd0);
        chk("s40_count", {48'd0, rd_count}, 64'd0);
        @(posedge ACLK); #1 ARESET = 0;
        chk("s40_arready_rel", {63'd0, bus.ARREADY}, 64'd0);
        @(posedge ACLK); #1;
        chk("s40_arready_edge", {63'd0, bus.ARREADY}, 64'd1);
        ar(32'h20); rcv(d, r);
        chk("s40_reg_zero", d, 64'd0);
        chk("s40_resp", {62'd0, r}, 64'd0);
        chk("s40_count1", {48'd0, rd_count}, 64'd1);
        repeat (2) @(posedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
